serializer_tx: RTL and testbench

//  Last stage of the PHY transmit path. Consumes the byte stream and byte-valid produced by the
//  4-lane byte-striping mux tree and drives a 1-bit serial line, MSB first.

---
 rtl/serializer_tx.sv | 120 ++++++++++++
 tb/tb_serializer_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serializer_tx.sv
// -----------------------------------------------------------------------------
// serializer_tx
//   Final stage of the PHY transmit path. Takes bytes (plus a byte-valid flag)
//   from the byte-striping mux tree and shifts them out on a single serial line,
//   MSB first. Runs on the bit clock (8x the byte rate for WIDTH=8).
//
//   After reset it emits SYNC_IDLES training symbols (IDLE_SYM), then enters
//   ACTIVE, where every symbol slot carries either an upstream byte or, when
//   upstream has nothing valid, the SKIP_SYM filler.
//
// Parameters
//   WIDTH       symbol width in bits
//   IDLE_SYM    training symbol sent during SYNC
//   SKIP_SYM    filler symbol sent in ACTIVE when no valid byte is offered
//   SYNC_IDLES  number of training symbols before ACTIVE (>= 1)
//
// Ports
//   clk         bit clock, rising-edge active
//   reset_L     asynchronous active-low reset
//   data_in     byte from upstream, sampled only on a load edge in ACTIVE
//   valid_in    data_in carries a real byte, sampled with data_in
//   data_ready  one-cycle strobe, high the cycle before each ACTIVE load edge
//   data_out    serial output (MSB of the shift register)
//   active      high while in ACTIVE
//   byte_cnt    count of valid bytes serialized, wraps at 16 bits
// -----------------------------------------------------------------------------
module serializer_tx #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM   = 8'hBC,
    parameter logic [WIDTH-1:0] SKIP_SYM   = 8'h7C,
    parameter int               SYNC_IDLES = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             data_ready,
    output logic             data_out,
    output logic             active,
    output logic [15:0]      byte_cnt
);

    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Wide enough to hold SYNC_IDLES itself, the value reached on the last training load.
    localparam int SYNC_W = $clog2(SYNC_IDLES + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_IDLES - 1);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state,    state_nxt;
    logic [WIDTH-1:0]  shreg,    shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt,  bit_cnt_nxt;
    logic [SYNC_W-1:0] sync_cnt, sync_cnt_nxt;
    logic [15:0]       byte_cnt_nxt;
    logic              load;

    // bit_cnt resets to the last bit position, so the first edge after reset
    // release is already a load edge.
    assign load = (bit_cnt == LAST_BIT);

    // Outputs are decoded from registers only; data_ready has no input path.
    assign data_out   = shreg[WIDTH-1];
    assign active     = (state == ACTIVE);
    assign data_ready = (state == ACTIVE) && load;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SYNC;
            shreg    <= '0;
            bit_cnt  <= LAST_BIT;
            sync_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sync_cnt <= sync_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg << 1;
        bit_cnt_nxt  = bit_cnt + CNT_W'(1);
        sync_cnt_nxt = sync_cnt;
        byte_cnt_nxt = byte_cnt;

        if (load) begin
            bit_cnt_nxt = '0;
            case (state)
                SYNC: begin
                    shreg_nxt    = IDLE_SYM;
                    sync_cnt_nxt = sync_cnt + SYNC_W'(1);
                    if (sync_cnt == LAST_SYNC) begin
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (valid_in) begin
                        shreg_nxt    = data_in;
                        // Wraps silently from 16'hFFFF to 0.
                        byte_cnt_nxt = byte_cnt + 16'd1;
                    end else begin
                        shreg_nxt = SKIP_SYM;
                    end
                end
                default: begin
                    state_nxt = SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
module tb_serializer_tx;

    localparam int         WIDTH      = 8;
    localparam logic [7:0] IDLE       = 8'hBC;
    localparam logic [7:0] SKIP       = 8'h7C;
    localparam int         SYNC_IDLES = 4;

    logic        clk      = 1'b0;
    logic        reset_L  = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic        valid_in = 1'b0;
    logic        data_ready;
    logic        data_out;
    logic        active;
    logic [15:0] byte_cnt;

    int          checks = 0;
    int          errors = 0;
    bit          sb[$];
    bit          mon_en = 1'b0;
    bit          mon_exp;
    int          bit_idx = 0;
    logic [15:0] exp_byte_cnt = 16'h0000;

    serializer_tx #(
        .WIDTH      (WIDTH),
        .IDLE_SYM   (IDLE),
        .SKIP_SYM   (SKIP),
        .SYNC_IDLES (SYNC_IDLES)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .active     (active),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    // Serial-line scoreboard: one expected bit popped after every rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en && sb.size() > 0) begin
            mon_exp = sb.pop_front();
            checks++;
            if (data_out !== mon_exp) begin
                errors++;
                $display("FAIL serial_bit idx=%0d actual=%b required=%b", bit_idx, data_out, mon_exp);
            end
            bit_idx++;
        end
    end

    task automatic push_sym(input logic [7:0] s);
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(s[i]);
    endtask

    // Called at a negedge with reset_L low; releases reset and follows the training sequence.
    task automatic sync_sequence(input string tag);
        reset_L = 1'b1;
        for (int k = 0; k < SYNC_IDLES; k++) push_sym(IDLE);
        mon_en = 1'b1;
        for (int n = 1; n <= SYNC_IDLES * WIDTH; n++) begin
            @(negedge clk);
            checks++;
            if (active !== (n >= (SYNC_IDLES - 1) * WIDTH + 1)) begin
                errors++;
                $display("FAIL %s_active after_edge=%0d actual=%b required=%b", tag, n, active,
                         (n >= (SYNC_IDLES - 1) * WIDTH + 1));
            end
            checks++;
            if (data_ready !== (n == SYNC_IDLES * WIDTH)) begin
                errors++;
                $display("FAIL %s_data_ready after_edge=%0d actual=%b required=%b", tag, n, data_ready,
                         (n == SYNC_IDLES * WIDTH));
            end
        end
    endtask

    // Starts at a negedge; waits for data_ready, offers one symbol, returns at the negedge after the load.
    task automatic send_sym(input bit v, input logic [7:0] d, input bit glitch, input string tag);
        int waited;
        waited = 0;
        while (data_ready !== 1'b1) begin
            if (glitch) begin
                valid_in = ~valid_in;
                data_in  = 8'($urandom);
            end
            @(negedge clk);
            waited++;
            if (waited > 4 * WIDTH) begin
                checks++;
                errors++;
                $display("FAIL %s_ready_timeout actual=waited%0d required=le%0d", tag, waited, 4 * WIDTH);
                return;
            end
        end
        valid_in = v;
        data_in  = d;
        push_sym(v ? d : SKIP);
        if (v) exp_byte_cnt = exp_byte_cnt + 16'd1;
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = 8'h00;
        checks++;
        if (byte_cnt !== exp_byte_cnt) begin
            errors++;
            $display("FAIL %s_byte_cnt actual=%h required=%h", tag, byte_cnt, exp_byte_cnt);
        end
    endtask

    task automatic test_reset;
        reset_L = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 1'b0) begin errors++; $display("FAIL rst_data_out actual=%b required=0", data_out); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL rst_active actual=%b required=0", active); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready actual=%b required=0", data_ready); end
        checks++;
        if (byte_cnt !== 16'h0000) begin errors++; $display("FAIL rst_byte_cnt actual=%h required=0000", byte_cnt); end
        sync_sequence("sync1");
    endtask

    task automatic test_data_byte;
        send_sym(1'b1, 8'hA5, 1'b0, "byte_a5");
    endtask

    task automatic test_skip;
        send_sym(1'b0, 8'hFF, 1'b1, "skip1");
        send_sym(1'b0, 8'h00, 1'b1, "skip2");
        send_sym(1'b1, 8'h96, 1'b1, "glitch_valid");
    endtask

    task automatic test_back_to_back;
        send_sym(1'b1, 8'h01, 1'b0, "b2b_01");
        send_sym(1'b1, 8'h02, 1'b0, "b2b_02");
        send_sym(1'b1, 8'h03, 1'b0, "b2b_03");
        send_sym(1'b1, 8'h04, 1'b0, "b2b_04");
        send_sym(1'b1, IDLE,  1'b0, "verbatim_idle");
        send_sym(1'b1, SKIP,  1'b0, "verbatim_skip");
    endtask

    task automatic test_reset_mid;
        send_sym(1'b1, 8'hFF, 1'b0, "mid_ff");
        repeat (3) @(negedge clk);
        reset_L = 1'b0;
        mon_en  = 1'b0;
        sb.delete();
        exp_byte_cnt = 16'h0000;
        #1;
        checks++;
        if (data_out !== 1'b0) begin errors++; $display("FAIL mid_rst_data_out actual=%b required=0", data_out); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL mid_rst_active actual=%b required=0", active); end
        checks++;
        if (byte_cnt !== 16'h0000) begin errors++; $display("FAIL mid_rst_byte_cnt actual=%h required=0000", byte_cnt); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_data_ready actual=%b required=0", data_ready); end
        repeat (2) @(negedge clk);
        sync_sequence("sync2");
        send_sym(1'b1, 8'h3C, 1'b0, "post_rst");
    endtask

    task automatic test_wrap;
        force dut.byte_cnt = 16'hFFFF;
        #1;
        release dut.byte_cnt;
        exp_byte_cnt = 16'hFFFF;
        checks++;
        if (byte_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset actual=%h required=ffff", byte_cnt); end
        send_sym(1'b1, 8'h5A, 1'b0, "wrap");
    endtask

    initial begin
        test_reset;
        test_data_byte;
        test_skip;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        repeat (WIDTH) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
